// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: FSM state encoding, data width and parity helper.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_rx_state_e;

   // Even-parity bit over a data byte (1 when the byte holds an odd number of ones).
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages reset to 1 (idle line level).
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_phy.sv
// UART receiver PHY: 8 data bits LSB first, mid-bit sampling, framing/parity error pulses.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_phy
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_ready,
   output logic                      rx_frame_err,
   output logic                      rx_parity_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam uart_rx_state_e AFTER_DATA = PARITY;
`else
   localparam uart_rx_state_e AFTER_DATA = STOP;
`endif

   logic                      rxs_s;
   uart_rx_state_e            state_r, state_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;
   logic [2:0]                bit_idx_r, bit_idx_s;
   logic [UART_DATA_BITS-1:0] shift_r, shift_s;
   logic [UART_DATA_BITS-1:0] rx_data_r, data_s;
   logic                      par_err_r, par_err_s;
   logic                      ready_r, ready_s;
   logic                      ferr_r, ferr_s;
   logic                      perr_r, perr_s;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxs_s)
   );

   // Frame sequencing: next state, baud/bit counters, shift register and pulse requests.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      par_err_s = par_err_r;
      data_s    = rx_data_r;
      ready_s   = 1'b0;
      ferr_s    = 1'b0;
      perr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = '0;
            if (!rxs_s) begin
               state_s   = START;
               par_err_s = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_s = '0;
               if (!rxs_s) begin
                  state_s   = DATA;
                  bit_idx_s = 3'd0;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == CNT_FULL) begin
               cnt_s     = '0;
               shift_s   = {rxs_s, shift_r[UART_DATA_BITS-1:1]};
               bit_idx_s = bit_idx_r + 3'd1;
               if (bit_idx_r == LAST_BIT) begin
                  state_s = AFTER_DATA;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_r == CNT_FULL) begin
               cnt_s     = '0;
               par_err_s = rxs_s ^ even_parity(shift_r);
               state_s   = STOP;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
`endif
         STOP: begin
            if (cnt_r == CNT_FULL) begin
               cnt_s = '0;
               if (rxs_s) begin
                  if (par_err_r) begin
                     perr_s = 1'b1;
                  end else begin
                     ready_s = 1'b1;
                     data_s  = shift_r;
                  end
                  state_s = IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = WAIT_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         // Hold off until the line returns high so a break cannot retrigger a frame.
         WAIT_IDLE: begin
            cnt_s = '0;
            if (rxs_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_IDLE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State, datapath and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= '0;
         rx_data_r <= '0;
         par_err_r <= 1'b0;
         ready_r   <= 1'b0;
         ferr_r    <= 1'b0;
         perr_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
         rx_data_r <= data_s;
         par_err_r <= par_err_s;
         ready_r   <= ready_s;
         ferr_r    <= ferr_s;
         perr_r    <= perr_s;
      end
   end

   assign rx_data       = rx_data_r;
   assign rx_ready      = ready_r;
   assign rx_frame_err  = ferr_r;
   assign rx_parity_err = perr_r;

endmodule

// File: tb/tb_uart_rx_phy.sv
// Scoreboard bench for uart_rx_phy (CLKS_PER_BIT=16, SYNC_STAGES=2); expected events queued by stimulus.
module tb_uart_rx_phy;
   import uart_pkg::*;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic [1:0] EV_READY = 2'd0;
   localparam logic [1:0] EV_FERR  = 2'd1;
   localparam logic [1:0] EV_PERR  = 2'd2;

   typedef struct {
      logic [1:0] kind;
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_frame_err;
   logic       rx_parity_err;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   last_ready_cyc;
   logic [7:0] prev_data;

   uart_rx_phy #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rxd           (rxd),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] data, input int gap);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic bit_time(input logic v, input int n);
      rxd = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
      bit_time(1'b0, CPB);
      for (int i = 0; i < 8; i++) bit_time(b[i], CPB);
      if (PAR_EN) bit_time(par_v, CPB);
      bit_time(stop_v, CPB);
   endtask

   // Monitor: pop an expected event on every output pulse and compare.
   initial begin
      cyc = 0;
      last_ready_cyc = 0;
      prev_data = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_data = 8'h00;
         end else begin
            if (rx_ready || rx_frame_err || rx_parity_err) begin
               check("pulse_exclusive", 32'(rx_ready + rx_frame_err + rx_parity_err), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: actual ready=%0b ferr=%0b perr=%0b required none",
                           rx_ready, rx_frame_err, rx_parity_err);
               end else begin
                  exp_t e;
                  logic [1:0] k;
                  e = exp_q.pop_front();
                  k = rx_ready ? EV_READY : (rx_frame_err ? EV_FERR : EV_PERR);
                  check("event_kind", 32'(k), 32'(e.kind));
                  check("event_rx_data", 32'(rx_data), 32'(e.data));
                  if (e.gap != 0) check("ready_gap", 32'(cyc - last_ready_cyc), 32'(e.gap));
               end
               if (rx_ready) last_ready_cyc = cyc;
            end
            if (!rx_ready && (rx_data !== prev_data)) begin
               checks++;
               errors++;
               $display("FAIL rx_data_hold: actual=0x%0h required=0x%0h", rx_data, prev_data);
            end
            prev_data = rx_data;
         end
      end
   end

   initial begin
      int wait_cyc;
      checks = 0;
      errors = 0;
      rxd    = 1'b1;
      rst_n  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_ready", 32'(rx_ready), 32'd0);
      check("reset_frame_err", 32'(rx_frame_err), 32'd0);
      check("reset_parity_err", 32'(rx_parity_err), 32'd0);
      check("reset_state", 32'(dut.state_r), 32'(IDLE));
      @(posedge clk);
      rst_n = 1'b1;
      bit_time(1'b1, 20);

      // Single byte 0x55.
      push(EV_READY, 8'h55, 0);
      send_frame(8'h55, 1'b1, ^8'h55);
      bit_time(1'b1, 20);

      // Back-to-back 0xA5, 0x3C.
      push(EV_READY, 8'hA5, 0);
      push(EV_READY, 8'h3C, PAR_EN ? 11 * CPB : 10 * CPB);
      send_frame(8'hA5, 1'b1, ^8'hA5);
      send_frame(8'h3C, 1'b1, ^8'h3C);
      bit_time(1'b1, 20);

      // Short glitch rejected.
      bit_time(1'b0, 4);
      bit_time(1'b1, 40);
      check("glitch_state", 32'(dut.state_r), 32'(IDLE));
      check("glitch_rx_data", 32'(rx_data), 32'h3C);

      // 0x81 with low stop bit held low: frame error, then wait for idle.
      push(EV_FERR, 8'h3C, 0);
      send_frame(8'h81, 1'b0, ^8'h81);
      bit_time(1'b0, 30);
      #1;
      check("break_state_wait_idle", 32'(dut.state_r), 32'(WAIT_IDLE));
      bit_time(1'b0, 20);
      bit_time(1'b1, 10);
      #1;
      check("break_state_idle", 32'(dut.state_r), 32'(IDLE));
      check("break_rx_data", 32'(rx_data), 32'h3C);
      bit_time(1'b1, 10);

      // Reset during bit 4 of 0xF0, then receive 0x0F.
      bit_time(1'b0, CPB);
      bit_time(1'b0, 4 * CPB);
      bit_time(1'b1, CPB / 2);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_rx_data", 32'(rx_data), 32'h00);
      check("midframe_reset_state", 32'(dut.state_r), 32'(IDLE));
      repeat (3) @(posedge clk);
      rxd   = 1'b1;
      rst_n = 1'b1;
      bit_time(1'b1, 20);
      push(EV_READY, 8'h0F, 0);
      send_frame(8'h0F, 1'b1, ^8'h0F);
      bit_time(1'b1, 20);
      check("after_reset_rx_data", 32'(rx_data), 32'h0F);

`ifdef UART_RX_PARITY_EN
      // 0x07: correct even parity is 1.
      push(EV_READY, 8'h07, 0);
      send_frame(8'h07, 1'b1, 1'b1);
      bit_time(1'b1, 20);
      push(EV_PERR, 8'h07, 0);
      send_frame(8'h07, 1'b1, 1'b0);
      bit_time(1'b1, 20);
      check("parity_rx_data", 32'(rx_data), 32'h07);
`endif

      wait_cyc = 0;
      while (exp_q.size() != 0 && wait_cyc < 400) begin
         @(posedge clk);
         wait_cyc++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_phy.md
UART_RX_PHY -- requirements
Module: uart_rx_phy

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..3).
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port rxd, input, 1: asynchronous serial line, idle high.
REQ-006 Port rx_data, output, 8: last correctly received byte.
REQ-007 Port rx_ready, output, 1: one-cycle pulse, rx_data newly valid.
REQ-008 Port rx_frame_err, output, 1: one-cycle pulse, stop bit sampled low.
REQ-009 Port rx_parity_err, output, 1: one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-010 rxd SHALL pass through SYNC_STAGES flops, reset value 1; the FSM SHALL only observe the synchronized bit rxs.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; the baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and the bit index 3 bits wide.
REQ-012 IDLE: on rxs==0 go to START with counter cleared; otherwise stay.
REQ-013 START: at counter==CLKS_PER_BIT/2-1 (integer floor) sample rxs; 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at counter==CLKS_PER_BIT-1 sample rxs into the shift register, LSB first (shift right, insert at bit 7), clear counter, increment bit index; after bit index 7, go to PARITY if enabled, else STOP.
REQ-015 Counters SHALL wrap to 0 only by explicit clear; no state SHALL let the counter exceed CLKS_PER_BIT-1.
REQ-016 STOP: at counter==CLKS_PER_BIT-1 sample rxs; 1 with no pending parity error -> load rx_data from the shift register, pulse rx_ready, go to IDLE; 1 with pending parity error -> pulse rx_parity_err only, go to IDLE; 0 -> pulse rx_frame_err only, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rxs==1, then IDLE (prevents break/stuck-low retriggering).
REQ-018 rx_ready, rx_frame_err and rx_parity_err SHALL be registered, high exactly one cycle, mutually exclusive.
REQ-019 rx_data SHALL change only on an rx_ready cycle and otherwise hold.
REQ-020 Latency: rx_ready SHALL rise SYNC_STAGES+1 cycles after the mid-stop-bit point on rxd (start edge + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT in 8N1).
REQ-021 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-022 rst_n low SHALL immediately force FSM IDLE, counters 0, shift register 0, rx_data 0x00, all pulse outputs 0, synchronizer flops 1.
REQ-023 Reset mid-frame SHALL abandon the frame with no pulse; after release the next falling edge is treated as a start bit.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7, sampled in PARITY at counter==CLKS_PER_BIT-1; mismatch against XOR of data bits is held as pending and reported per REQ-016.
REQ-025 Macro UART_RX_PARITY_EN undefined: 8N1 framing, PARITY state unreachable, rx_parity_err tied 0.

Structure
REQ-026 Shared package uart_pkg SHALL hold the uart_rx_state_e enum and the UART_DATA_BITS=8 constant.
REQ-027 The synchronizer SHALL be a sub-module sync_ff (parameter STAGES, reset value 1); no other sub-modules.

Verification (CLKS_PER_BIT=16, SYNC_STAGES=2)
REQ-028 Send 0x55 8N1 -> exactly one rx_ready pulse, rx_data=0x55, no error pulses.
REQ-029 Send 0xA5 then 0x3C back-to-back -> two rx_ready pulses 160 cycles apart, rx_data 0xA5 then 0x3C.
REQ-030 rxd low for 4 cycles then high -> FSM returns to IDLE, no pulses, rx_data unchanged.
REQ-031 Send 0x81 with stop bit low, hold rxd low 50 cycles -> one rx_frame_err, no rx_ready, rx_data unchanged, FSM in WAIT_IDLE until rxd high.
REQ-032 Assert rst_n low during bit 4 of 0xF0, release, send 0x0F -> no pulse for 0xF0, rx_data=0x0F after second frame.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_ready, rx_data=0x07; parity 0 -> rx_parity_err only, rx_data unchanged.
